bcd_serial_subtractor: RTL and testbench
========================================

# bcd_serial_subtractor

Digit-serial, multi-digit BCD subtractor computing |A − B| and its sign. It adds A to the 9's complement of B with end-around carry, one BCD digit per clock. It consumes the same 4-bit-per-digit BCD encoding, and the same "digit > 9 is invalid" rule, as our combinational 9's-complement converter. It sits behind the digit-entry datapath and feeds the display/sign logic.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*DIGITS  minuend, BCD, digit 0 at bits [3:0]
- b  input  4*DIGITS  subtrahend, BCD
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  4*DIGITS  BCD magnitude |A − B|
- neg  output  1  1 when A < B
- invalid  output  1  1 when any digit of a or b exceeds 9

## Operation
- States: IDLE, ADD, FIX, COMP, DONE.
- IDLE, start=1:
  - Latch a, b; clear digit index and carry.
  - If any digit of a or b is >9: invalid=1, result=0, neg=0, go to DONE.
  - Otherwise: invalid=0, go to ADD.
- ADD, one digit i per cycle, i=0..DIGITS−1:
  - s = A_i + (9 − B_i) + c, 5-bit.
  - If s > 9: P_i = s − 10, c = 1. Otherwise: P_i = s, c = 0.
  - After digit DIGITS−1, branch on the final carry:
    - c=1 → FIX (A ≥ B... strictly A > B or equal handled below).
    - c=0 → COMP.
- FIX (end-around carry), one digit per cycle, carry-in 1:
  - P_i + c; 10 wraps to 0 with carry out.
  - Cannot overflow out of the top digit.
  - Result = P, neg=0, then DONE.
- COMP, single cycle:
  - result digit i = 9 − P_i, all digits in parallel.
  - neg=1, except neg=0 if the resulting magnitude is all zero (A = B yields no negative zero).
  - Then DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Output holding:
  - result, neg and invalid are held from DONE until the next accepted start.
  - Internal partial values never appear on result before DONE.
- start is ignored whenever state ≠ IDLE. Latched operands are unaffected by a/b changes after acceptance.
- Reset (any time, including mid-operation): state=IDLE; busy, done, neg, invalid = 0; result = 0; no done pulse for an aborted operation.

## Timing
- Edge k is the edge where start is accepted. Done is high in the cycle following the listed edge:
  - A > B: edge k+2·DIGITS (DIGITS ADD + DIGITS FIX).
  - A ≤ B: edge k+DIGITS+1 (ADD + COMP).
  - invalid: edge k+1.
- busy rises at edge k. It falls at the edge that enters IDLE from DONE, i.e. one cycle after done.
- Earliest next start: the cycle after done (state IDLE).
- All outputs are registered. There is no combinational path from a, b or start to any output.

## Test plan
- DIGITS=4, a=0x5432, b=0x1234, start → result=0x4198, neg=0, invalid=0, done one cycle after edge k+8; busy high for 9 cycles.
- a=0x1234, b=0x5432 → result=0x4198, neg=1, done after edge k+5.
- a=b=0x0777 → result=0x0000, neg=0 (no negative zero), done after edge k+5.
- End-around ripple cases:
  - a=0x9999, b=0x0000 → result=0x9999, neg=0.
  - a=0x1000, b=0x0001 → result=0x0999, neg=0.
- a=0x12A4, b=0x0001 → invalid=1, result=0, neg=0, done after edge k+1.
- Reset and start-while-busy:
  - Start a=0x5432, b=0x1234.
  - Pulse start again during ADD → ignored, result still 0x4198.
  - Restart, then assert rst mid-FIX → busy/done/result/neg/invalid all 0 immediately, no done pulse.
  - A new start after rst is released completes normally.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial BCD subtractor: |A - B| and sign via 9's complement
// addition with end-around carry, one digit per clock.
module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] result,
    output logic                neg,
    output logic                invalid
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {IDLE, ADD, FIX, COMP, DONE} state_t;

    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   p;
    logic [IW-1:0]  idx;
    logic           c;

    logic           bad;
    logic [4:0]     s;
    logic           add_c;
    logic [3:0]     add_d;
    logic [3:0]     fix_sum;
    logic           fix_c;
    logic [3:0]     fix_d;
    logic [W-1:0]   comp_r;
    logic           all_nine;
    logic           last;
    logic [W-1:0]   p_add;
    logic [W-1:0]   p_fix;

    always_comb begin
        bad      = 1'b0;
        comp_r   = '0;
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9)
                bad = 1'b1;
            comp_r[4*i +: 4] = 4'd9 - p[4*i +: 4];
            if (p[4*i +: 4] != 4'd9)
                all_nine = 1'b0;
        end
    end

    // Digits are consumed from bit 0 and partial digits enter from the top,
    // so after DIGITS shifts P is aligned with digit 0 at bits [3:0].
    always_comb begin
        s       = {1'b0, a_q[3:0]} + {1'b0, 4'd9 - b_q[3:0]} + {4'd0, c};
        add_c   = s > 5'd9;
        add_d   = add_c ? 4'(s - 5'd10) : s[3:0];
        fix_sum = p[3:0] + {3'd0, c};
        fix_c   = fix_sum == 4'd10;
        fix_d   = fix_c ? 4'd0 : fix_sum;
        p_add   = W'({add_d, p} >> 4);
        p_fix   = W'({fix_d, p} >> 4);
        last    = idx == IW'(DIGITS - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p       <= '0;
            idx     <= '0;
            c       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            neg     <= 1'b0;
            invalid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        p       <= '0;
                        idx     <= '0;
                        c       <= 1'b0;
                        busy    <= 1'b1;
                        result  <= '0;
                        neg     <= 1'b0;
                        invalid <= bad;
                        state   <= bad ? DONE : ADD;
                    end
                end
                ADD: begin
                    p   <= p_add;
                    a_q <= a_q >> 4;
                    b_q <= b_q >> 4;
                    // Final carry doubles as the FIX stage carry-in.
                    c   <= add_c;
                    idx <= last ? '0 : idx + 1'b1;
                    if (last)
                        state <= add_c ? FIX : COMP;
                end
                FIX: begin
                    p   <= p_fix;
                    c   <= fix_c;
                    idx <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        result <= p_fix;
                        neg    <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                COMP: begin
                    result <= comp_r;
                    neg    <= ~all_nine;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    // Invalid operands arrive here without done raised yet.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor with directed vectors.
module tb_bcd_serial_subtractor;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        neg;
    logic        invalid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [15:0] res;
        logic        neg;
        logic        inv;
        int          cyc;
    } exp_t;

    exp_t q[$];

    bcd_serial_subtractor #(.DIGITS(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .result(result),
        .neg(neg),
        .invalid(invalid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (result !== e.res || neg !== e.neg ||
                    invalid !== e.inv || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL done_out got r=%h n=%b i=%b cyc=%0d want r=%h n=%b i=%b cyc=%0d",
                             result, neg, invalid, cyc,
                             e.res, e.neg, e.inv, e.cyc);
                end
            end
        end
    end

    task automatic run(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [15:0] er, input logic en,
                       input logic ei, input int lat, input bit poke);
        int nb;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        q.push_back('{er, en, ei, cyc + 1 + lat});
        @(negedge clk);
        start = 1'b0;
        a = 16'h9876;
        b = 16'h0123;
        nb = busy ? 1 : 0;
        for (int i = 0; i < 60 && busy; i++) begin
            start = (poke && i == 1);
            if (poke && i == 1) begin
                a = 16'h1111;
                b = 16'h8888;
            end
            @(negedge clk);
            if (busy) nb++;
        end
        start = 1'b0;
        checks++;
        if (nb != lat + 1 || q.size() != 0) begin
            errors++;
            $display("FAIL busy_len got %0d pend=%0d want %0d pend=0",
                     nb, q.size(), lat + 1);
            q.delete();
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, result, neg, invalid} !== '0) begin
            errors++;
            $display("FAIL reset_state got b=%b d=%b r=%h n=%b i=%b want 0",
                     busy, done, result, neg, invalid);
        end
        rst = 1'b0;
        @(negedge clk);

        run(16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 8, 1'b0);
        run(16'h1234, 16'h5432, 16'h4198, 1'b1, 1'b0, 5, 1'b0);
        run(16'h0777, 16'h0777, 16'h0000, 1'b0, 1'b0, 5, 1'b0);
        run(16'h9999, 16'h0000, 16'h9999, 1'b0, 1'b0, 8, 1'b0);
        run(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0, 8, 1'b0);
        run(16'h0000, 16'h9999, 16'h9999, 1'b1, 1'b0, 5, 1'b0);
        run(16'h12A4, 16'h0001, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run(16'h0001, 16'h000F, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
        run(16'h5432, 16'h1234, 16'h4198, 1'b0, 1'b0, 8, 1'b1);

        checks++;
        if (result !== 16'h4198 || neg !== 1'b0) begin
            errors++;
            $display("FAIL hold_result got r=%h n=%b want r=4198 n=0",
                     result, neg);
        end

        @(negedge clk);
        a = 16'h5432;
        b = 16'h1234;
        start = 1'b1;
        q.push_back('{16'h4198, 1'b0, 1'b0, cyc + 9});
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        checks++;
        if ({busy, done, result, neg, invalid} !== '0) begin
            errors++;
            $display("FAIL mid_reset got b=%b d=%b r=%h n=%b i=%b want 0",
                     busy, done, result, neg, invalid);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if ({busy, done, result} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got b=%b d=%b r=%h want 0",
                     busy, done, result);
        end

        run(16'h2500, 16'h0499, 16'h2001, 1'b0, 1'b0, 8, 1'b0);
        run(16'h0499, 16'h2500, 16'h2001, 1'b1, 1'b0, 5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
